// File: rtl/uart_tx_buffer.sv
`timescale 1ns/1ps
// uart_tx_buffer: CPU-loaded DEPTH-byte message streamed in order to a UART transmitter.
// Latency: first tx_start one cycle after the start write; each next byte one cycle after tx_done.
// Backpressure: one byte in flight, next tx_start waits for tx_done; buffer writes ignored while busy.
module uart_tx_buffer #(
    parameter int DEPTH = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] address,
    input  logic [7:0] w_data,
    output logic [7:0] r_data,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] CTRL_ADDR = 3'(DEPTH);
    localparam logic [2:0] LAST_PTR  = 3'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] rd_ptr;
    logic [2:0] nxt_ptr;
    logic [7:0] mem [DEPTH];

    logic data_wr;
    logic ctrl_wr;
    logic start_cmd;
    logic clear_cmd;

    assign data_wr   = we && (address < CTRL_ADDR) && (state == IDLE);
    assign ctrl_wr   = we && (address == CTRL_ADDR);
    assign start_cmd = ctrl_wr && w_data[0] && (state == IDLE);
    assign clear_cmd = ctrl_wr && w_data[1];
    assign nxt_ptr   = rd_ptr + 3'd1;

    always_comb begin
        r_data = 8'h00;
        if (address < CTRL_ADDR)
            r_data = mem[address];
        else if (address == CTRL_ADDR)
            r_data = {6'b0, busy, done};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else if (data_wr) begin
            mem[address] <= w_data;
        end
    end

    // done is cleared first so that a same-edge set from the last tx_done takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_ptr   <= 3'd0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (clear_cmd)
                done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_cmd) begin
                        rd_ptr   <= 3'd0;
                        tx_data  <= mem[0];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (tx_done) begin
                        if (rd_ptr == LAST_PTR) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            rd_ptr   <= nxt_ptr;
                            tx_data  <= mem[nxt_ptr];
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
`timescale 1ns/1ps
// Randomized self-checking bench for uart_tx_buffer with a transmitter responder and byte-level model.
module tb_uart_tx_buffer;
    localparam int         DEPTH = 5;
    localparam logic [2:0] CTRL  = 3'(DEPTH);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       we = 1'b0;
    logic [2:0] address = 3'd0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       busy;
    logic       done;

    logic resp_done = 1'b0;
    logic spur_done = 1'b0;
    assign tx_done = resp_done | spur_done;

    bit         resp_en = 1'b0;
    int         fixed_lat = 10;
    int         resp_lat;
    int         n_vec = 0;
    int         n_err = 0;
    int         wide_cnt = 0;
    bit         prev_start = 1'b0;
    logic [7:0] model_mem [DEPTH];
    logic [7:0] cap_q [$];

    uart_tx_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .address (address),
        .w_data  (w_data),
        .r_data  (r_data),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_done (tx_done),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Record every transmit request and flag any that lasts more than one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                cap_q.push_back(tx_data);
                if (prev_start) wide_cnt++;
            end
            prev_start = (tx_start === 1'b1);
        end
    end

    // Transmitter model: tx_done pulse resp_lat cycles after each observed tx_start.
    initial begin
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (resp_en && tx_start === 1'b1) begin
                resp_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 12));
                repeat (resp_lat) @(negedge clk);
                resp_done = 1'b1;
            end
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; address = a; w_data = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        #1 d = r_data;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        for (int a = 0; a <= DEPTH; a++) begin
            read_reg(3'(a), d);
            n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_read[%0d]: got %h want 00", a, d); end
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_send();
        bit         to;
        logic [7:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = 8'(17 * (i + 1));
            cpu_write(3'(i), model_mem[i]);
        end
        fixed_lat = 10; resp_en = 1'b1;
        cap_q.delete(); wide_cnt = 0;
        cpu_write(CTRL, 8'h01);
        wait_idle(400, to);
        repeat (5) @(negedge clk);
        n_vec++; if (to) begin n_err++; $display("FAIL basic_timeout: busy still %b want 0", busy); end
        n_vec++; if (cap_q.size() != DEPTH) begin n_err++; $display("FAIL basic_count: got %0d want %0d", cap_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < cap_q.size(); i++) begin
            n_vec++; if (cap_q[i] !== model_mem[i]) begin n_err++; $display("FAIL basic_byte[%0d]: got %h want %h", i, cap_q[i], model_mem[i]); end
        end
        n_vec++; if (wide_cnt != 0) begin n_err++; $display("FAIL basic_pulse_width: got %0d wide want 0", wide_cnt); end
        read_reg(CTRL, d);
        n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL basic_status: got %h want 01", d); end
    endtask

    task automatic test_busy_writes();
        bit         to;
        int         n;
        logic [7:0] d;
        cap_q.delete();
        cpu_write(CTRL, 8'h03);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (tx_start === 1'b1) begin n++; if (n == 2) break; end
            @(negedge clk);
        end
        n_vec++; if (n != 2) begin n_err++; $display("FAIL busy_wr_sync: got %0d starts want 2", n); end
        cpu_write(3'd2, 8'hAA);
        cpu_write(CTRL, 8'h01);
        wait_idle(400, to);
        repeat (5) @(negedge clk);
        n_vec++; if (to) begin n_err++; $display("FAIL busy_wr_timeout: busy still %b want 0", busy); end
        n_vec++; if (cap_q.size() != DEPTH) begin n_err++; $display("FAIL busy_wr_count: got %0d want %0d", cap_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < cap_q.size(); i++) begin
            n_vec++; if (cap_q[i] !== model_mem[i]) begin n_err++; $display("FAIL busy_wr_byte[%0d]: got %h want %h", i, cap_q[i], model_mem[i]); end
        end
        read_reg(3'd2, d);
        n_vec++; if (d !== model_mem[2]) begin n_err++; $display("FAIL busy_wr_readback: got %h want %h", d, model_mem[2]); end
    endtask

    task automatic test_done_handling();
        bit         to;
        logic [7:0] d;
        cpu_write(CTRL, 8'h02);
        read_reg(CTRL, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL done_clear: got %h want 00", d); end
        cpu_write(CTRL, 8'h01);
        wait_idle(400, to);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL done_set: got %b want 1", done); end
        cap_q.delete();
        cpu_write(CTRL, 8'h03);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_clr_start_done: got %b want 0", done); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL done_clr_start_busy: got %b want 1", busy); end
        n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL done_clr_start_txs: got %b want 1", tx_start); end
        n_vec++; if (tx_data !== model_mem[0]) begin n_err++; $display("FAIL done_clr_start_data: got %h want %h", tx_data, model_mem[0]); end
        wait_idle(400, to);
        n_vec++; if (to || done !== 1'b1) begin n_err++; $display("FAIL done_resend: done %b timeout %b want 1/0", done, to); end
    endtask

    task automatic test_random_sends();
        bit         to;
        logic [7:0] d;
        logic [2:0] a;
        fixed_lat = 0;
        for (int iter = 0; iter < 4; iter++) begin
            if (iter % 2 == 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    model_mem[i] = 8'($urandom);
                    cpu_write(3'(i), model_mem[i]);
                end
            end
            cpu_write(3'($urandom_range(DEPTH + 1, 7)), 8'($urandom));
            cap_q.delete();
            cpu_write(CTRL, {6'b0, 1'($urandom_range(0, 1)), 1'b1});
            wait_idle(600, to);
            repeat (3) @(negedge clk);
            n_vec++; if (to || cap_q.size() != DEPTH) begin n_err++; $display("FAIL rand_count[%0d]: got %0d timeout %b want %0d", iter, cap_q.size(), to, DEPTH); end
            for (int i = 0; i < DEPTH && i < cap_q.size(); i++) begin
                n_vec++; if (cap_q[i] !== model_mem[i]) begin n_err++; $display("FAIL rand_byte[%0d][%0d]: got %h want %h", iter, i, cap_q[i], model_mem[i]); end
            end
            read_reg(CTRL, d);
            n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL rand_status[%0d]: got %h want 01", iter, d); end
            a = 3'($urandom_range(DEPTH + 1, 7));
            read_reg(a, d);
            n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL rand_unused[%0d]: got %h want 00", a, d); end
            a = 3'($urandom_range(0, DEPTH - 1));
            read_reg(a, d);
            n_vec++; if (d !== model_mem[a]) begin n_err++; $display("FAIL rand_read[%0d]: got %h want %h", a, d, model_mem[a]); end
        end
        fixed_lat = 10;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_spurious();
        bit found;
        resp_en = 1'b0;
        cap_q.delete();
        cpu_write(CTRL, 8'h03);
        for (int b = 0; b < DEPTH; b++) begin
            found = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (tx_start === 1'b1) begin found = 1'b1; break; end
                @(negedge clk);
            end
            n_vec++; if (!found) begin n_err++; $display("FAIL spur_start[%0d]: got no tx_start want one", b); end
            if (b == 1) begin
                spur_done = 1'b1;
                @(negedge clk);
                spur_done = 1'b0;
            end
            repeat (3) @(negedge clk);
            spur_done = 1'b1;
            if (b == DEPTH - 1) begin we = 1'b1; address = CTRL; w_data = 8'h02; end
            @(negedge clk);
            spur_done = 1'b0; we = 1'b0;
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL spur_collision_done: got %b want 1", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL spur_collision_busy: got %b want 0", busy); end
        repeat (5) @(negedge clk);
        n_vec++; if (cap_q.size() != DEPTH) begin n_err++; $display("FAIL spur_send_count: got %0d want %0d", cap_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < cap_q.size(); i++) begin
            n_vec++; if (cap_q[i] !== model_mem[i]) begin n_err++; $display("FAIL spur_byte[%0d]: got %h want %h", i, cap_q[i], model_mem[i]); end
        end
        cap_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); spur_done = 1'b1;
            @(negedge clk); spur_done = 1'b0;
            n_vec++; if (tx_start !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL spur_idle[%0d]: tx_start %b busy %b want 0/0", i, tx_start, busy); end
        end
        repeat (3) @(negedge clk);
        n_vec++; if (cap_q.size() != 0 || done !== 1'b1) begin n_err++; $display("FAIL spur_idle_state: starts %0d done %b want 0/1", cap_q.size(), done); end
    endtask

    task automatic test_reset_midsend();
        int         n;
        logic [7:0] d;
        fixed_lat = 10; resp_en = 1'b1;
        cpu_write(CTRL, 8'h03);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (tx_start === 1'b1) begin n++; if (n == 3) break; end
            @(negedge clk);
        end
        n_vec++; if (n != 3) begin n_err++; $display("FAIL rst_mid_sync: got %0d starts want 3", n); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL rst_mid_tx_start: got %b want 0", tx_start); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_vec++; if (tx_data !== 8'h00 || done !== 1'b0) begin n_err++; $display("FAIL rst_mid_outputs: tx_data %h done %b want 00/0", tx_data, done); end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        cap_q.delete();
        repeat (30) @(negedge clk);
        n_vec++; if (cap_q.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_after: starts %0d busy %b want 0/0", cap_q.size(), busy); end
        read_reg(3'd2, d);
        n_vec++; if (d !== model_mem[2]) begin n_err++; $display("FAIL rst_mid_cleared: got %h want %h", d, model_mem[2]); end
    endtask

    initial begin
        test_reset();
        test_basic_send();
        test_busy_writes();
        test_done_handling();
        test_random_sends();
        test_spurious();
        test_reset_midsend();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
